// File: rtl/acc_stream_source.sv
// acc_stream_source: buffers upstream IEEE-754 samples in a show-ahead FIFO
// and releases a commanded number of them as one AXI-stream frame, with
// m_tlast on the final word of the frame.
module acc_stream_source #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     start,
  input  logic [LEN_W-1:0]         frame_len,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     m_tvalid,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tlast,
  input  logic                     m_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // state | meaning
  // IDLE   | no frame running; words may accumulate in the FIFO
  // STREAM | frame running; remaining_q words still to hand over
  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              done_q, done_d;

  logic push;
  logic pop;

  // Handshake qualifiers and outputs, all derived from registered state only
  // so m_tvalid can never follow m_tready combinationally.
  assign in_ready   = (level_q != LW'(DEPTH));
  assign m_tvalid   = (state_q == STREAM) && (level_q != '0);
  assign m_tlast    = m_tvalid && (remaining_q == LEN_W'(1));
  assign m_tdata    = m_tvalid ? mem[rd_ptr_q] : '0;
  assign busy       = (state_q == STREAM);
  assign done       = done_q;
  assign fifo_level = level_q;

  assign push = in_valid && in_ready;
  assign pop  = m_tvalid && m_tready;

  // FIFO storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Frame sequencing: accept a non-zero start in IDLE, count handshakes down,
  // return to IDLE with a one-cycle done after the last word.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d     = STREAM;
          remaining_d = frame_len;
        end
      end
      STREAM: begin
        if (pop) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // All control registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

endmodule
